// File: rtl/if_fetch.sv
// Instruction-fetch stage: PC generation, credit-limited req/gnt/rvalid fetch, and an
// in-order output buffer of {pc, inst} pairs with branch flush and kill of stale responses.
module if_fetch #(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int unsigned       DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [INST_W-1:0] imem_rdata_i,
  output logic [ADDR_W-1:0] if_pc_o,
  output logic [INST_W-1:0] if_inst_o,
  output logic              if_valid_o
);

  localparam int unsigned      CNT_W     = $clog2(DEPTH + 1);
  localparam int unsigned      PTR_W     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  logic              run_q;
  logic [ADDR_W-1:0] pc_q;

  // PCs of requests granted but not yet answered, including killed ones
  logic [ADDR_W-1:0] fl_pc_q [DEPTH];
  logic [PTR_W-1:0]  fl_rd_q, fl_wr_q;
  logic [CNT_W-1:0]  fl_cnt_q;

  logic [ADDR_W-1:0] ob_pc_q   [DEPTH];
  logic [INST_W-1:0] ob_inst_q [DEPTH];
  logic [PTR_W-1:0]  ob_rd_q, ob_wr_q;
  logic [CNT_W-1:0]  ob_cnt_q;

  logic [CNT_W-1:0]  kill_q;

  logic [CNT_W:0] used;
  logic           credit, accept, rsp, keep, ob_pop;

  always_comb begin
    used        = {1'b0, fl_cnt_q} + {1'b0, ob_cnt_q};
    credit      = used < {1'b0, CNT_DEPTH};
    // run_q keeps req low while in reset and for the first edge after release
    imem_req_o  = run_q & credit & ~branch_flag_i;
    imem_addr_o = pc_q;
    accept      = imem_req_o & imem_gnt_i;
    rsp         = imem_rvalid_i & (fl_cnt_q != '0);
    keep        = rsp & (kill_q == '0) & ~branch_flag_i;
    if_valid_o  = ob_cnt_q != '0;
    ob_pop      = if_valid_o & ~stall_i & ~branch_flag_i;
    if_pc_o     = if_valid_o ? ob_pc_q[ob_rd_q] : '0;
    if_inst_o   = if_valid_o ? ob_inst_q[ob_rd_q] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q    <= 1'b0;
      pc_q     <= RESET_PC;
      fl_rd_q  <= '0;
      fl_wr_q  <= '0;
      fl_cnt_q <= '0;
      ob_rd_q  <= '0;
      ob_wr_q  <= '0;
      ob_cnt_q <= '0;
      kill_q   <= '0;
    end else begin
      run_q <= 1'b1;
      if (accept) begin
        pc_q    <= pc_q + ADDR_W'(4);
        fl_wr_q <= ptr_inc(fl_wr_q);
      end
      if (rsp) fl_rd_q <= ptr_inc(fl_rd_q);
      fl_cnt_q <= fl_cnt_q + CNT_W'(accept) - CNT_W'(rsp);

      if (branch_flag_i) begin
        pc_q     <= branch_target_i;
        ob_rd_q  <= '0;
        ob_wr_q  <= '0;
        ob_cnt_q <= '0;
        // Everything still outstanding after this cycle's pop belongs to the old path
        kill_q   <= fl_cnt_q - CNT_W'(rsp);
      end else begin
        if (rsp && kill_q != '0) kill_q <= kill_q - 1'b1;
        if (keep) ob_wr_q <= ptr_inc(ob_wr_q);
        if (ob_pop) ob_rd_q <= ptr_inc(ob_rd_q);
        ob_cnt_q <= ob_cnt_q + CNT_W'(keep) - CNT_W'(ob_pop);
      end
    end
  end

  // Storage arrays carry no reset; counts gate every read
  always_ff @(posedge clk) begin
    if (accept) fl_pc_q[fl_wr_q] <= pc_q;
    if (keep) begin
      ob_pc_q[ob_wr_q]   <= fl_pc_q[fl_rd_q];
      ob_inst_q[ob_wr_q] <= imem_rdata_i;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a small in-order memory responder plus hand-derived
// cycle-by-cycle expectations for fetch, stall, gnt back-pressure, branch kill and reset.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, branch_flag_i;
  logic [31:0] branch_target_i;
  logic        imem_req_o, imem_gnt_i, imem_rvalid_i;
  logic [31:0] imem_addr_o, imem_rdata_i;
  logic [31:0] if_pc_o, if_inst_o;
  logic        if_valid_o;

  int          n_checks = 0;
  int          n_errors = 0;
  int          gnt_cnt  = 0;
  bit          mem_auto = 1'b1;
  logic [31:0] mq[$];

  always #5 clk = ~clk;

  if_fetch dut (
    .clk             (clk),
    .rst             (rst),
    .stall_i         (stall_i),
    .branch_flag_i   (branch_flag_i),
    .branch_target_i (branch_target_i),
    .imem_req_o      (imem_req_o),
    .imem_addr_o     (imem_addr_o),
    .imem_gnt_i      (imem_gnt_i),
    .imem_rvalid_i   (imem_rvalid_i),
    .imem_rdata_i    (imem_rdata_i),
    .if_pc_o         (if_pc_o),
    .if_inst_o       (if_inst_o),
    .if_valid_o      (if_valid_o)
  );

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {~a[15:0], a[15:0]};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock; memory answers in order, one cycle after gnt, while mem_auto is set
  task automatic tick();
    logic        acc, rv;
    logic [31:0] acc_addr;
    acc      = imem_req_o & imem_gnt_i;
    acc_addr = imem_addr_o;
    rv       = imem_rvalid_i;
    @(posedge clk);
    #1;
    if (rv && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      mq.push_back(acc_addr);
      gnt_cnt++;
    end
    if (mem_auto && mq.size() > 0) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = inst_of(mq[0]);
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0; mem_auto = 1'b1;
    mq.delete();
    tick();
    tick();
    rst = 1'b1;
    tick();
    gnt_cnt = 0;
  endtask

  initial begin
    rst = 1'b0;
    stall_i = 1'b0; branch_flag_i = 1'b0; branch_target_i = '0; imem_gnt_i = 1'b0;
    imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    tick();
    check_eq("rst_req", 32'(imem_req_o), 32'd0);
    check_eq("rst_valid", 32'(if_valid_o), 32'd0);
    check_eq("rst_pc", if_pc_o, 32'h0);
    check_eq("rst_inst", if_inst_o, 32'h0);
    check_eq("rst_addr", imem_addr_o, 32'h0);

    // 1: streaming fetch, 1-cycle memory latency
    do_reset();
    imem_gnt_i = 1'b1; #1;
    check_eq("t1_c1_req", 32'(imem_req_o), 32'd1);
    check_eq("t1_c1_addr", imem_addr_o, 32'h0);
    check_eq("t1_c1_valid", 32'(if_valid_o), 32'd0);
    tick();
    check_eq("t1_c2_addr", imem_addr_o, 32'h4);
    check_eq("t1_c2_valid", 32'(if_valid_o), 32'd0);
    tick();
    check_eq("t1_c3_valid", 32'(if_valid_o), 32'd1);
    check_eq("t1_c3_pc", if_pc_o, 32'h0);
    check_eq("t1_c3_inst", if_inst_o, inst_of(32'h0));
    check_eq("t1_c3_req", 32'(imem_req_o), 32'd0);
    tick();
    check_eq("t1_c4_pc", if_pc_o, 32'h4);
    check_eq("t1_c4_inst", if_inst_o, inst_of(32'h4));
    check_eq("t1_c4_addr", imem_addr_o, 32'h8);
    tick();
    check_eq("t1_c5_valid", 32'(if_valid_o), 32'd0);
    tick();
    check_eq("t1_c6_pc", if_pc_o, 32'h8);
    check_eq("t1_c6_inst", if_inst_o, inst_of(32'h8));

    // 2: stall fills buffer, credit stops requests, release drains in order
    do_reset();
    imem_gnt_i = 1'b1; stall_i = 1'b1; #1;
    tick(); tick(); tick();
    check_eq("t2_c4_pc", if_pc_o, 32'h0);
    check_eq("t2_c4_req", 32'(imem_req_o), 32'd0);
    tick(); tick();
    check_eq("t2_grants", 32'(gnt_cnt), 32'd2);
    check_eq("t2_c6_pc", if_pc_o, 32'h0);
    check_eq("t2_c6_req", 32'(imem_req_o), 32'd0);
    stall_i = 1'b0; #1;
    tick();
    check_eq("t2_c7_valid", 32'(if_valid_o), 32'd1);
    check_eq("t2_c7_pc", if_pc_o, 32'h4);
    check_eq("t2_c7_inst", if_inst_o, inst_of(32'h4));
    tick();
    check_eq("t2_c8_valid", 32'(if_valid_o), 32'd0);

    // 3: gnt held low, req/addr stay put
    do_reset();
    imem_gnt_i = 1'b1; #1;
    tick(); tick(); tick();
    imem_gnt_i = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("t3_hold%0d_req", i), 32'(imem_req_o), 32'd1);
      check_eq($sformatf("t3_hold%0d_addr", i), imem_addr_o, 32'h8);
      if (i < 2) tick();
    end
    imem_gnt_i = 1'b1; #1;
    tick();
    check_eq("t3_after_addr", imem_addr_o, 32'hC);
    check_eq("t3_after_req", 32'(imem_req_o), 32'd1);

    // 4: two in flight, branch kills both responses
    do_reset();
    imem_gnt_i = 1'b1; branch_flag_i = 1'b1; branch_target_i = 32'h10; mem_auto = 1'b0; #1;
    check_eq("t4_br_req", 32'(imem_req_o), 32'd0);
    tick();
    branch_flag_i = 1'b0; #1;
    check_eq("t4_c2_addr", imem_addr_o, 32'h10);
    tick();
    check_eq("t4_c3_addr", imem_addr_o, 32'h14);
    tick();
    branch_flag_i = 1'b1; branch_target_i = 32'h100; mem_auto = 1'b1; #1;
    check_eq("t4_c4_req", 32'(imem_req_o), 32'd0);
    tick();
    branch_flag_i = 1'b0; #1;
    check_eq("t4_c5_valid", 32'(if_valid_o), 32'd0);
    check_eq("t4_c5_req", 32'(imem_req_o), 32'd0);
    check_eq("t4_c5_addr", imem_addr_o, 32'h100);
    tick();
    check_eq("t4_c6_valid", 32'(if_valid_o), 32'd0);
    check_eq("t4_c6_req", 32'(imem_req_o), 32'd1);
    tick();
    check_eq("t4_c7_valid", 32'(if_valid_o), 32'd0);
    tick();
    check_eq("t4_c8_valid", 32'(if_valid_o), 32'd1);
    check_eq("t4_c8_pc", if_pc_o, 32'h100);
    check_eq("t4_c8_inst", if_inst_o, inst_of(32'h100));

    // 5: branch coincides with rvalid and stall
    do_reset();
    imem_gnt_i = 1'b1; stall_i = 1'b1; #1;
    tick(); tick();
    check_eq("t5_c3_pc", if_pc_o, 32'h0);
    check_eq("t5_c3_rvalid", 32'(imem_rvalid_i), 32'd1);
    branch_flag_i = 1'b1; branch_target_i = 32'h100; #1;
    check_eq("t5_br_req", 32'(imem_req_o), 32'd0);
    tick();
    branch_flag_i = 1'b0; #1;
    check_eq("t5_c4_valid", 32'(if_valid_o), 32'd0);
    check_eq("t5_c4_req", 32'(imem_req_o), 32'd1);
    check_eq("t5_c4_addr", imem_addr_o, 32'h100);
    tick(); tick();
    check_eq("t5_c6_pc", if_pc_o, 32'h100);
    check_eq("t5_c6_inst", if_inst_o, inst_of(32'h100));

    // 6: async reset mid-fetch, back-to-back branches, pc wrap
    do_reset();
    imem_gnt_i = 1'b1; stall_i = 1'b1; #1;
    tick(); tick();
    rst = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0; mq.delete(); #1;
    check_eq("t6_rst_req", 32'(imem_req_o), 32'd0);
    check_eq("t6_rst_valid", 32'(if_valid_o), 32'd0);
    check_eq("t6_rst_pc", if_pc_o, 32'h0);
    check_eq("t6_rst_inst", if_inst_o, 32'h0);
    check_eq("t6_rst_addr", imem_addr_o, 32'h0);
    tick();
    rst = 1'b1; stall_i = 1'b0;
    tick();
    check_eq("t6_restart_req", 32'(imem_req_o), 32'd1);
    check_eq("t6_restart_addr", imem_addr_o, 32'h0);
    branch_flag_i = 1'b1; branch_target_i = 32'h200; #1;
    tick();
    branch_target_i = 32'h300; #1;
    check_eq("t6_b2b_req", 32'(imem_req_o), 32'd0);
    tick();
    branch_flag_i = 1'b0; #1;
    check_eq("t6_b2b_addr", imem_addr_o, 32'h300);
    branch_flag_i = 1'b1; branch_target_i = 32'hFFFF_FFFC; #1;
    tick();
    branch_flag_i = 1'b0; #1;
    check_eq("t6_wrap_pre", imem_addr_o, 32'hFFFF_FFFC);
    tick();
    check_eq("t6_wrap_addr", imem_addr_o, 32'h0);
    check_eq("t6_wrap_req", 32'(imem_req_o), 32'd1);
    tick();
    check_eq("t6_wrap_pc", if_pc_o, 32'hFFFF_FFFC);
    check_eq("t6_wrap_inst", if_inst_o, inst_of(32'hFFFF_FFFC));

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
